// File: rtl/adc_pkg.sv
// Shared types and default sizing for the serial ADC sampling path.
package adc_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } adc_state_e;

    localparam int ADC_BITS_DEF   = 12;
    localparam int FRAME_BITS_DEF = 16;
    localparam int LEAD_ZEROS_DEF = 4;
    localparam int SCLK_HALF_DEF  = 1;
    localparam int IDX_W_DEF      = 16;

endpackage : adc_pkg

// File: rtl/spi_frame_rx.sv
// SPI frame receiver: drives CS_N/SCLK for one FRAME_BITS conversion and
// shifts in the DATA_BITS that follow the LEAD_ZEROS leading bits.
module spi_frame_rx
    import adc_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int LEAD_ZEROS = LEAD_ZEROS_DEF,
    parameter int DATA_BITS  = ADC_BITS_DEF,
    parameter int SCLK_HALF  = SCLK_HALF_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sdata,
    output logic                 cs_n,
    output logic                 sclk,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] frame
);

    localparam int BIT_W  = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int HALF_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

    adc_state_e           state_r;
    adc_state_e           state_nx_s;
    logic                 cs_n_r;
    logic                 sclk_r;
    logic                 busy_r;
    logic [BIT_W-1:0]     bit_cnt_r;
    logic [HALF_W-1:0]    half_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 half_end_s;
    logic                 last_bit_s;
    logic                 capture_s;
    logic                 rise_s;

    assign half_end_s = (half_cnt_r == HALF_W'(SCLK_HALF - 1));
    assign last_bit_s = (bit_cnt_r == BIT_W'(FRAME_BITS - 1));
    assign capture_s  = (bit_cnt_r >= BIT_W'(LEAD_ZEROS));
    assign rise_s     = (state_r == SHIFT) && half_end_s && !sclk_r;

    assign cs_n  = cs_n_r;
    assign sclk  = sclk_r;
    assign busy  = busy_r;
    assign done  = (state_r == DONE);
    assign frame = shift_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode: the frame ends on the SCLK rise of the last bit
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = SETUP;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SETUP: state_nx_s = SHIFT;
            SHIFT: begin
                if (rise_s && last_bit_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = SHIFT;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // SPI pins, bit/phase counters and data capture on each SCLK rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_n_r     <= 1'b1;
            sclk_r     <= 1'b1;
            busy_r     <= 1'b0;
            bit_cnt_r  <= {BIT_W{1'b0}};
            half_cnt_r <= {HALF_W{1'b0}};
            shift_r    <= {DATA_BITS{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        cs_n_r <= 1'b0;
                        busy_r <= 1'b1;
                    end
                end
                SETUP: begin
                    sclk_r     <= 1'b0;
                    bit_cnt_r  <= {BIT_W{1'b0}};
                    half_cnt_r <= {HALF_W{1'b0}};
                end
                SHIFT: begin
                    if (half_end_s) begin
                        half_cnt_r <= {HALF_W{1'b0}};
                        if (!sclk_r) begin
                            sclk_r <= 1'b1;
                            if (capture_s) begin
                                shift_r <= {shift_r[DATA_BITS-2:0], sdata};
                            end
                            if (!last_bit_s) begin
                                bit_cnt_r <= bit_cnt_r + BIT_W'(1'b1);
                            end
                        end else begin
                            sclk_r <= 1'b0;
                        end
                    end else begin
                        half_cnt_r <= half_cnt_r + HALF_W'(1'b1);
                    end
                end
                DONE: begin
                    cs_n_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                default: begin
                    cs_n_r <= 1'b1;
                    sclk_r <= 1'b1;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule : spi_frame_rx

// File: rtl/adc_sample_ctrl.sv
// Turns DO_SAMPLE transitions into serial ADC reads, tags each sample with
// its index inside the current stimulus period and flags dropped requests.
module adc_sample_ctrl
    import adc_pkg::*;
#(
    parameter int ADC_BITS   = ADC_BITS_DEF,
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int LEAD_ZEROS = LEAD_ZEROS_DEF,
    parameter int SCLK_HALF  = SCLK_HALF_DEF,
    parameter int IDX_W      = IDX_W_DEF
) (
    input  logic                CLK_500K,
    input  logic                RST_N,
    input  logic                DO_SAMPLE,
    input  logic                VSTIM_P,
    input  logic                ADC_SDATA,
    output logic                ADC_CS_N,
    output logic                ADC_SCLK,
    output logic [ADC_BITS-1:0] SAMPLE_DATA,
    output logic [IDX_W-1:0]    SAMPLE_INDEX,
    output logic                SAMPLE_VALID,
    output logic                OVERRUN,
    output logic                BUSY
);

    logic                do_sample_d_r;
    logic                vstim_p_d_r;
    logic                req_s;
    logic                stim_rise_s;
    logic                busy_s;
    logic                done_s;
    logic                accept_s;
    logic                drop_s;
    logic [ADC_BITS-1:0] frame_s;
    logic [IDX_W-1:0]    cnt_r;
    logic [IDX_W-1:0]    idx_lat_r;
    logic                cnt_max_s;

    assign req_s       = DO_SAMPLE ^ do_sample_d_r;
    assign stim_rise_s = VSTIM_P & ~vstim_p_d_r;
    assign accept_s    = req_s & ~busy_s;
    assign drop_s      = req_s & busy_s;
    assign cnt_max_s   = &cnt_r;
    assign BUSY        = busy_s;

    spi_frame_rx #(
        .FRAME_BITS (FRAME_BITS),
        .LEAD_ZEROS (LEAD_ZEROS),
        .DATA_BITS  (ADC_BITS),
        .SCLK_HALF  (SCLK_HALF)
    ) u_rx (
        .clk   (CLK_500K),
        .rst_n (RST_N),
        .start (accept_s),
        .sdata (ADC_SDATA),
        .cs_n  (ADC_CS_N),
        .sclk  (ADC_SCLK),
        .busy  (busy_s),
        .done  (done_s),
        .frame (frame_s)
    );

    // Delay registers for request/period edge detection
    always_ff @(posedge CLK_500K or negedge RST_N) begin
        if (!RST_N) begin
            do_sample_d_r <= 1'b0;
            vstim_p_d_r   <= 1'b0;
        end else begin
            do_sample_d_r <= DO_SAMPLE;
            vstim_p_d_r   <= VSTIM_P;
        end
    end

    // Period-relative index: latch on acceptance, saturating count, cleared by period start
    always_ff @(posedge CLK_500K or negedge RST_N) begin
        if (!RST_N) begin
            cnt_r     <= {IDX_W{1'b0}};
            idx_lat_r <= {IDX_W{1'b0}};
        end else if (accept_s) begin
            if (stim_rise_s) begin
                idx_lat_r <= {IDX_W{1'b0}};
                cnt_r     <= IDX_W'(1'b1);
            end else begin
                idx_lat_r <= cnt_r;
                if (!cnt_max_s) begin
                    cnt_r <= cnt_r + IDX_W'(1'b1);
                end
            end
        end else if (stim_rise_s) begin
            cnt_r <= {IDX_W{1'b0}};
        end
    end

    // Registered sample outputs and status pulses
    always_ff @(posedge CLK_500K or negedge RST_N) begin
        if (!RST_N) begin
            SAMPLE_DATA  <= {ADC_BITS{1'b0}};
            SAMPLE_INDEX <= {IDX_W{1'b0}};
            SAMPLE_VALID <= 1'b0;
            OVERRUN      <= 1'b0;
        end else begin
            SAMPLE_VALID <= done_s;
            OVERRUN      <= drop_s;
            if (done_s) begin
                SAMPLE_DATA  <= frame_s;
                SAMPLE_INDEX <= idx_lat_r;
            end
        end
    end

endmodule : adc_sample_ctrl

// File: tb/tb_adc_sample_ctrl.sv
// Scoreboard bench for adc_sample_ctrl with a behavioural serial ADC model.
`timescale 1ns/1ps
module tb_adc_sample_ctrl;

    logic        CLK_500K = 1'b0;
    logic        RST_N;
    logic        DO_SAMPLE;
    logic        VSTIM_P;
    logic        ADC_SDATA;
    logic        ADC_CS_N;
    logic        ADC_SCLK;
    logic [11:0] SAMPLE_DATA;
    logic [15:0] SAMPLE_INDEX;
    logic        SAMPLE_VALID;
    logic        OVERRUN;
    logic        BUSY;

    typedef struct packed {
        logic [11:0] data;
        logic [15:0] idx;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    int          valid_cnt = 0;
    int          overrun_cnt = 0;
    int          sclk_rises = 0;
    logic [15:0] adc_word = 16'h0000;
    int          adc_bit = 0;

    adc_sample_ctrl dut (
        .CLK_500K     (CLK_500K),
        .RST_N        (RST_N),
        .DO_SAMPLE    (DO_SAMPLE),
        .VSTIM_P      (VSTIM_P),
        .ADC_SDATA    (ADC_SDATA),
        .ADC_CS_N     (ADC_CS_N),
        .ADC_SCLK     (ADC_SCLK),
        .SAMPLE_DATA  (SAMPLE_DATA),
        .SAMPLE_INDEX (SAMPLE_INDEX),
        .SAMPLE_VALID (SAMPLE_VALID),
        .OVERRUN      (OVERRUN),
        .BUSY         (BUSY)
    );

    always #1000 CLK_500K = ~CLK_500K;

    // ADC model: frame restarts on CS_N fall, next bit presented on each SCLK fall
    always @(negedge ADC_CS_N) adc_bit = 0;
    always @(negedge ADC_SCLK) begin
        if (adc_bit < 16) begin
            ADC_SDATA = adc_word[15 - adc_bit];
            adc_bit = adc_bit + 1;
        end else begin
            ADC_SDATA = 1'b0;
        end
    end

    always @(posedge ADC_SCLK) sclk_rises++;

    // Monitor: pulse counters and scoreboard compare on every SAMPLE_VALID
    always @(negedge CLK_500K) begin
        if (OVERRUN === 1'b1) overrun_cnt++;
        if (SAMPLE_VALID === 1'b1) begin
            valid_cnt++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_valid: got data=%h idx=%0d, required no sample", SAMPLE_DATA, SAMPLE_INDEX);
            end else begin
                mon_e = sb_q.pop_front();
                if (SAMPLE_DATA !== mon_e.data || SAMPLE_INDEX !== mon_e.idx) begin
                    errors++;
                    $display("FAIL sb_sample: got data=%h idx=%0d, required data=%h idx=%0d",
                             SAMPLE_DATA, SAMPLE_INDEX, mon_e.data, mon_e.idx);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK_500K);
    endtask

    task automatic apply_reset();
        @(negedge CLK_500K);
        RST_N = 1'b0;
        DO_SAMPLE = 1'b0;
        VSTIM_P = 1'b0;
        tick(3);
        RST_N = 1'b1;
        sb_q.delete();
        tick(1);
    endtask

    task automatic push_exp(input logic [11:0] d, input logic [15:0] i);
        sb_q.push_back({d, i});
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        DO_SAMPLE = 1'b0;
        VSTIM_P = 1'b0;
        tick(2);
        checks++;
        if ({ADC_CS_N, ADC_SCLK, SAMPLE_VALID, OVERRUN, BUSY} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_ctrl: got cs,sclk,valid,ovr,busy=%b, required 11000",
                     {ADC_CS_N, ADC_SCLK, SAMPLE_VALID, OVERRUN, BUSY});
        end
        checks++;
        if (SAMPLE_DATA !== 12'h000) begin
            errors++;
            $display("FAIL reset_data: got %h, required 000", SAMPLE_DATA);
        end
        checks++;
        if (SAMPLE_INDEX !== 16'd0) begin
            errors++;
            $display("FAIL reset_index: got %0d, required 0", SAMPLE_INDEX);
        end
        RST_N = 1'b1;
        tick(1);
    endtask

    task automatic test_single();
        int v0;
        int cs_low;
        int vat;
        apply_reset();
        adc_word = 16'h5ABC;   // non-zero leading bits must be discarded
        sclk_rises = 0;
        v0 = valid_cnt;
        cs_low = 0;
        vat = -1;
        DO_SAMPLE = ~DO_SAMPLE;
        push_exp(12'hABC, 16'd0);
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK_500K);
            if (ADC_CS_N === 1'b0) cs_low++;
            if (SAMPLE_VALID === 1'b1 && vat < 0) vat = i;
            if (i == 1) begin
                checks++;
                if (BUSY !== 1'b1 || ADC_CS_N !== 1'b0) begin
                    errors++;
                    $display("FAIL single_start: got busy=%b cs_n=%b, required 1 0", BUSY, ADC_CS_N);
                end
            end
        end
        checks++;
        if (cs_low != 33) begin
            errors++;
            $display("FAIL single_cs_len: got %0d cycles, required 33", cs_low);
        end
        checks++;
        if (sclk_rises != 16) begin
            errors++;
            $display("FAIL single_sclk: got %0d rises, required 16", sclk_rises);
        end
        checks++;
        if (vat != 34) begin
            errors++;
            $display("FAIL single_valid_edge: got sample %0d, required 34 (edge n+33)", vat);
        end
        checks++;
        if (valid_cnt - v0 != 1 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL single_count: got %0d valids, %0d pending, required 1 and 0", valid_cnt - v0, sb_q.size());
        end
    endtask

    task automatic test_polarity();
        int v0;
        apply_reset();
        v0 = valid_cnt;
        adc_word = 16'h0001;
        DO_SAMPLE = 1'b1;
        push_exp(12'h001, 16'd0);
        tick(40);
        adc_word = 16'h0FFF;
        DO_SAMPLE = 1'b0;
        push_exp(12'hFFF, 16'd1);
        tick(40);
        checks++;
        if (valid_cnt - v0 != 2 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL polarity_count: got %0d valids, %0d pending, required 2 and 0", valid_cnt - v0, sb_q.size());
        end
    endtask

    task automatic test_overrun();
        int v0;
        int o0;
        apply_reset();
        v0 = valid_cnt;
        o0 = overrun_cnt;
        adc_word = 16'h0123;
        DO_SAMPLE = ~DO_SAMPLE;
        push_exp(12'h123, 16'd0);
        for (int i = 1; i <= 35; i++) begin
            @(negedge CLK_500K);
            if (i == 10) DO_SAMPLE = ~DO_SAMPLE;     // seen at edge n+10
            if (i == 33) begin                       // seen at edge n+33
                DO_SAMPLE = ~DO_SAMPLE;
                adc_word = 16'h0456;
            end
            if (i == 34) begin                       // seen at edge n+34
                checks++;
                if (SAMPLE_VALID !== 1'b1 || BUSY !== 1'b0) begin
                    errors++;
                    $display("FAIL overrun_first_done: got valid=%b busy=%b, required 1 0", SAMPLE_VALID, BUSY);
                end
                DO_SAMPLE = ~DO_SAMPLE;
                push_exp(12'h456, 16'd1);
            end
            if (i == 35) begin
                checks++;
                if (ADC_CS_N !== 1'b0 || BUSY !== 1'b1) begin
                    errors++;
                    $display("FAIL overrun_accept_n34: got cs_n=%b busy=%b, required 0 1", ADC_CS_N, BUSY);
                end
            end
        end
        tick(40);
        checks++;
        if (overrun_cnt - o0 != 2) begin
            errors++;
            $display("FAIL overrun_pulses: got %0d, required 2", overrun_cnt - o0);
        end
        checks++;
        if (valid_cnt - v0 != 2 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL overrun_valids: got %0d valids, %0d pending, required 2 and 0", valid_cnt - v0, sb_q.size());
        end
    endtask

    task automatic test_period();
        int v0;
        apply_reset();
        v0 = valid_cnt;
        for (int k = 0; k < 5; k++) begin
            adc_word = 16'h0100 + 16'(k);
            DO_SAMPLE = ~DO_SAMPLE;
            push_exp(12'h100 + 12'(k), 16'(k));
            tick(40);
        end
        adc_word = 16'h0555;
        DO_SAMPLE = ~DO_SAMPLE;
        push_exp(12'h555, 16'd5);
        tick(10);
        VSTIM_P = 1'b1;                             // period restarts mid-frame
        tick(1);
        VSTIM_P = 1'b0;
        tick(29);
        adc_word = 16'h0666;
        DO_SAMPLE = ~DO_SAMPLE;
        push_exp(12'h666, 16'd0);
        tick(40);
        adc_word = 16'h0777;
        VSTIM_P = 1'b1;                             // period start on the accepting edge
        DO_SAMPLE = ~DO_SAMPLE;
        push_exp(12'h777, 16'd0);
        tick(1);
        VSTIM_P = 1'b0;
        tick(39);
        adc_word = 16'h0888;
        DO_SAMPLE = ~DO_SAMPLE;
        push_exp(12'h888, 16'd1);
        tick(40);
        checks++;
        if (valid_cnt - v0 != 9 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL period_count: got %0d valids, %0d pending, required 9 and 0", valid_cnt - v0, sb_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int v0;
        apply_reset();
        adc_word = 16'h0321;
        DO_SAMPLE = ~DO_SAMPLE;
        push_exp(12'h321, 16'd0);
        tick(40);
        adc_word = 16'h0AAA;
        DO_SAMPLE = ~DO_SAMPLE;
        push_exp(12'hAAA, 16'd1);
        tick(12);
        checks++;
        if (ADC_CS_N !== 1'b0 || ADC_SCLK !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre: got cs_n=%b sclk=%b, required 0 0", ADC_CS_N, ADC_SCLK);
        end
        RST_N = 1'b0;
        DO_SAMPLE = 1'b0;
        #1;
        checks++;
        if ({ADC_CS_N, ADC_SCLK, SAMPLE_VALID, OVERRUN, BUSY} !== 5'b11000) begin
            errors++;
            $display("FAIL midrst_ctrl: got cs,sclk,valid,ovr,busy=%b, required 11000",
                     {ADC_CS_N, ADC_SCLK, SAMPLE_VALID, OVERRUN, BUSY});
        end
        checks++;
        if (SAMPLE_DATA !== 12'h000 || SAMPLE_INDEX !== 16'd0) begin
            errors++;
            $display("FAIL midrst_data: got data=%h idx=%0d, required 000 0", SAMPLE_DATA, SAMPLE_INDEX);
        end
        sb_q.delete();
        v0 = valid_cnt;
        tick(3);
        RST_N = 1'b1;
        tick(40);
        checks++;
        if (valid_cnt != v0) begin
            errors++;
            $display("FAIL midrst_novalid: got %0d valids, required 0", valid_cnt - v0);
        end
        adc_word = 16'h0BCD;
        DO_SAMPLE = ~DO_SAMPLE;
        push_exp(12'hBCD, 16'd0);
        tick(40);
        checks++;
        if (valid_cnt - v0 != 1 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_after: got %0d valids, %0d pending, required 1 and 0", valid_cnt - v0, sb_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int v0;
        int o0;
        apply_reset();
        v0 = valid_cnt;
        o0 = overrun_cnt;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                adc_word = 16'h0200 + 16'(k);
                push_exp(12'h200 + 12'(k), 16'(k / 2));
            end
            DO_SAMPLE = ~DO_SAMPLE;
            tick(20);
        end
        tick(20);
        checks++;
        if (overrun_cnt - o0 != 3) begin
            errors++;
            $display("FAIL b2b_overrun: got %0d, required 3", overrun_cnt - o0);
        end
        checks++;
        if (valid_cnt - v0 != 3 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_valids: got %0d valids, %0d pending, required 3 and 0", valid_cnt - v0, sb_q.size());
        end
    endtask

    initial begin
        RST_N = 1'b0;
        DO_SAMPLE = 1'b0;
        VSTIM_P = 1'b0;
        ADC_SDATA = 1'b0;
        test_reset();
        test_single();
        test_polarity();
        test_overrun();
        test_period();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_adc_sample_ctrl
